// File: rtl/layer_norm_lanes.sv
// layer_norm_lanes: normalises one N-element signed vector, P lanes per beat.
//   mode=0 LayerNorm (subtract the mean, scale by 1/std), mode=1 RMSNorm (no mean).
//   Each element then gets its gamma scale and beta shift.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, mode           start pulse (accepted in IDLE only), mode select
//   x_in, gamma, beta     operand vectors, held stable while busy
//   rsqrt_req/in/ack/out  handshake with the shared rsqrt unit (var -> 1/sqrt(var))
//   busy, done            operation in progress / one-cycle completion pulse
//   y_out, out_valid      registered result vector and its valid flag

// One lane: x - mean and its square for the accumulators, plus the
// two-stage output pipeline (rsqrt scale, then gamma/beta and saturation).
module ln_lane #(
  parameter int DW  = 8,
  parameter int GW  = 16,
  parameter int GSH = 8,
  parameter int RSH = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [DW-1:0]   x,
  input  logic [DW-1:0]   mean,
  input  logic [15:0]     r,
  input  logic [GW-1:0]   gamma,
  input  logic [DW-1:0]   beta,
  output logic [DW:0]     xd,
  output logic [2*DW+1:0] sq,
  output logic [DW-1:0]   y
);
  localparam int PW  = DW + 19;
  localparam int GPW = 24 + GW + 1;

  logic signed [DW:0]     xd_s;
  logic signed [2*DW+1:0] sq_s;
  logic signed [PW-1:0]   p1, p1s;
  logic signed [23:0]     n_q;
  logic signed [GW-1:0]   g_q;
  logic signed [DW-1:0]   b_q;
  logic signed [GPW-1:0]  gp, s2;

  // No saturation on the difference: one extra bit always holds it.
  assign xd_s = (DW+1)'($signed(x)) - (DW+1)'($signed(mean));
  assign sq_s = xd_s * xd_s;
  assign xd   = xd_s;
  assign sq   = sq_s;

  // r is unsigned, so it gets a zero sign bit before the signed multiply.
  assign p1  = PW'(xd_s) * PW'($signed({1'b0, r})) + PW'(2**(RSH-1));
  assign p1s = p1 >>> RSH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else if (en) begin
      n_q <= 24'(p1s);
      g_q <= $signed(gamma);
      b_q <= $signed(beta);
    end
  end

  assign gp = (GPW'(n_q) * GPW'(g_q)) >>> GSH;
  assign s2 = gp + GPW'(b_q);

  always_comb begin
    y = DW'(s2);
    if (s2 > GPW'(2**(DW-1)-1))     y = DW'(2**(DW-1)-1);
    else if (s2 < GPW'(-2**(DW-1))) y = DW'(-2**(DW-1));
  end
endmodule

module layer_norm_lanes #(
  parameter int N         = 176,
  parameter int P         = 4,
  parameter int DW        = 8,
  parameter int GW        = 16,
  parameter int GSH       = 8,
  parameter int RSH       = 12,
  parameter int AVG_MUL   = 93,
  parameter int AVG_SHIFT = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [N-1:0][DW-1:0]  x_in,
  input  logic [N-1:0][GW-1:0]  gamma,
  input  logic [N-1:0][DW-1:0]  beta,
  output logic                  rsqrt_req,
  output logic [15:0]           rsqrt_in,
  input  logic                  rsqrt_ack,
  input  logic [15:0]           rsqrt_out,
  output logic                  busy,
  output logic                  done,
  output logic [N-1:0][DW-1:0]  y_out,
  output logic                  out_valid
);
  localparam int B  = N / P;
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(N) + DW + 1;
  localparam int QW = 2*DW + 2 + $clog2(N);
  localparam int MW = SW + 34;
  localparam int VW = QW + 32;
  localparam logic signed [33:0] AMUL = 34'(AVG_MUL);

  typedef enum logic [2:0] {IDLE, MEAN, VAR, RSQRT, OUT, DRAIN} state_t;
  state_t state, nxt;

  logic [BW-1:0]            beat, bidx_q;
  logic                     last, issue;
  logic signed [SW-1:0]     sum_q, sum_nxt;
  logic [QW-1:0]            sq_q, sq_nxt;
  logic signed [DW-1:0]     mean_q, mean_sat;
  logic [15:0]              var_q, var_sat, r_q;
  logic signed [MW-1:0]     mprod, msh;
  logic [VW-1:0]            vprod, vsh;
  logic [1:0]               vld_pipe;  // [0] stage-1 regs valid, [1] y_out written
  logic [P-1:0][IW-1:0]     idx, widx;
  logic [P-1:0][DW:0]       xd_l;
  logic [P-1:0][2*DW+1:0]   sq_l;
  logic [P-1:0][DW-1:0]     y_l;

  assign last      = (beat == BW'(B-1));
  assign issue     = (state == OUT);
  assign rsqrt_req = (state == RSQRT);
  assign rsqrt_in  = var_q;

  always_comb begin
    idx  = '0;
    widx = '0;
    for (int j = 0; j < P; j++) begin
      idx[j]  = IW'(int'(beat) * P + j);
      widx[j] = IW'(int'(bidx_q) * P + j);
    end
  end

  for (genvar j = 0; j < P; j++) begin : g_lane
    ln_lane #(.DW(DW), .GW(GW), .GSH(GSH), .RSH(RSH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (issue),
      .x     (x_in[idx[j]]),
      .mean  (mean_q),
      .r     (r_q),
      .gamma (gamma[idx[j]]),
      .beta  (beta[idx[j]]),
      .xd    (xd_l[j]),
      .sq    (sq_l[j]),
      .y     (y_l[j])
    );
  end

  // mean_q is zero throughout MEAN, so the lane differences are the raw x values.
  always_comb begin
    sum_nxt = sum_q;
    sq_nxt  = sq_q;
    for (int j = 0; j < P; j++) begin
      sum_nxt = sum_nxt + SW'($signed(xd_l[j]));
      sq_nxt  = sq_nxt + QW'(sq_l[j]);
    end
  end

  always_comb begin
    mprod    = MW'(sum_nxt) * MW'(AMUL);
    msh      = mprod >>> AVG_SHIFT;
    mean_sat = DW'(msh);
    if (msh > MW'(2**(DW-1)-1))     mean_sat = DW'(2**(DW-1)-1);
    else if (msh < MW'(-2**(DW-1))) mean_sat = DW'(-2**(DW-1));
    vprod   = VW'(sq_nxt) * VW'(AVG_MUL);
    vsh     = vprod >> AVG_SHIFT;
    var_sat = (vsh > VW'(65535)) ? 16'hFFFF : vsh[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = mode ? VAR : MEAN;
      MEAN:    if (last) nxt = VAR;
      VAR:     if (last) nxt = RSQRT;
      RSQRT:   if (rsqrt_ack) nxt = OUT;
      OUT:     if (last) nxt = DRAIN;
      // Last beat has landed in y_out and nothing is left in stage 1.
      DRAIN:   if (vld_pipe == 2'b10) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat      <= '0;
      bidx_q    <= '0;
      sum_q     <= '0;
      sq_q      <= '0;
      mean_q    <= '0;
      var_q     <= '0;
      r_q       <= '0;
      vld_pipe  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      y_out     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          beat      <= '0;
          sum_q     <= '0;
          sq_q      <= '0;
          mean_q    <= '0;
          busy      <= 1'b1;
          out_valid <= 1'b0;
        end
        MEAN: begin
          beat  <= last ? '0 : beat + 1'b1;
          sum_q <= last ? '0 : sum_nxt;
          if (last) mean_q <= mean_sat;
        end
        VAR: begin
          beat <= last ? '0 : beat + 1'b1;
          sq_q <= last ? '0 : sq_nxt;
          if (last) var_q <= var_sat;
        end
        RSQRT: if (rsqrt_ack) r_q <= rsqrt_out;
        OUT:   beat <= last ? '0 : beat + 1'b1;
        DRAIN: if (vld_pipe == 2'b10) begin
          done      <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
      vld_pipe <= {vld_pipe[0], issue};
      if (issue) bidx_q <= beat;
      if (vld_pipe[0])
        for (int j = 0; j < P; j++) y_out[widx[j]] <= y_l[j];
    end
  end
endmodule

// File: tb/tb_layer_norm_lanes.sv
module tb_layer_norm_lanes;
  localparam int N = 8, P = 4, B = N / P, AM = 2048, AS = 14;

  logic clk = 1'b0;
  logic rst_n, start, mode, rsqrt_req, busy, done, out_valid;
  logic rsqrt_ack = 1'b0;
  logic [N-1:0][7:0]  x_in, beta, y_out;
  logic [N-1:0][15:0] gamma;
  logic [15:0] rsqrt_in;
  logic [15:0] rsqrt_out = 16'h0;

  typedef struct {
    logic               mode;
    logic [N-1:0][7:0]  x;
    logic [N-1:0][15:0] g;
    logic [N-1:0][7:0]  b;
    logic [15:0]        rs;
    int                 w;        // rsqrt cycles incl. the ack cycle
    int                 restart;  // cycle to pulse a second start, 0 = none
    logic [15:0]        ev;
    logic [N-1:0][7:0]  ey;
  } vec_t;

  vec_t tbl[5];
  vec_t sb[$];
  int total = 0, bad = 0;

  logic [15:0] rs_val = 16'h0;
  int ack_w = 1, req_cnt = 0;
  logic [15:0] var_seen = 16'h0;
  bit var_jump = 0;

  layer_norm_lanes #(.N(N), .P(P), .AVG_MUL(AM), .AVG_SHIFT(AS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .x_in(x_in), .gamma(gamma), .beta(beta),
    .rsqrt_req(rsqrt_req), .rsqrt_in(rsqrt_in), .rsqrt_ack(rsqrt_ack), .rsqrt_out(rsqrt_out),
    .busy(busy), .done(done), .y_out(y_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // rsqrt unit model: ack on the w-th requesting cycle, tracks operand stability.
  always @(negedge clk) begin
    if (rsqrt_req) begin
      if (req_cnt == 0) var_seen = rsqrt_in;
      else if (rsqrt_in !== var_seen) var_jump = 1;
      req_cnt++;
      rsqrt_ack = (req_cnt == ack_w);
    end else begin
      rsqrt_ack = 1'b0;
    end
    rsqrt_out = rs_val;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic m, input logic [7:0] xa, input logic [7:0] xb,
                              input logic [15:0] g, input logic [7:0] b, input logic [15:0] rs,
                              input int w, input int rst, input logic [15:0] ev,
                              input logic [7:0] ya, input logic [7:0] yb);
    vec_t v;
    v.mode = m; v.rs = rs; v.w = w; v.restart = rst; v.ev = ev;
    for (int i = 0; i < N; i++) begin
      v.x[i]  = (i % 2 == 0) ? xa : xb;
      v.g[i]  = g;
      v.b[i]  = b;
      v.ey[i] = (i % 2 == 0) ? ya : yb;
    end
    return v;
  endfunction

  function automatic vec_t model(input vec_t vi);
    vec_t v;
    longint s, m, sq, vr, xd, n, g, y;
    v = vi; s = 0; sq = 0;
    for (int i = 0; i < N; i++) s += longint'($signed(v.x[i]));
    m = v.mode ? 0 : (s * AM) >>> AS;
    if (m > 127) m = 127;
    if (m < -128) m = -128;
    for (int i = 0; i < N; i++) begin
      xd = longint'($signed(v.x[i])) - m;
      sq += xd * xd;
    end
    vr = (sq * AM) >>> AS;
    if (vr > 65535) vr = 65535;
    v.ev = vr[15:0];
    for (int i = 0; i < N; i++) begin
      xd = longint'($signed(v.x[i])) - m;
      n  = (xd * longint'(v.rs) + 2048) >>> 12;
      g  = (n * longint'($signed(v.g[i]))) >>> 8;
      y  = g + longint'($signed(v.b[i]));
      if (y > 127) y = 127;
      if (y < -128) y = -128;
      v.ey[i] = y[7:0];
    end
    return v;
  endfunction

  task automatic run(input vec_t v);
    int cyc;
    vec_t e;
    @(negedge clk);
    x_in = v.x; gamma = v.g; beta = v.b; mode = v.mode;
    rs_val = v.rs; ack_w = v.w; req_cnt = 0; var_jump = 0;
    start = 1'b1;
    sb.push_back(v);
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    chk("busy_set", busy, 1);
    chk("ovalid_clr", out_valid, 0);
    while (!done && cyc < 300) begin
      if (cyc == v.restart) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      cyc++;
    end
    e = sb.pop_front();
    chk("done_seen", done, 1);
    if (!done) return;
    chk("latency", cyc, (e.mode ? 2 : 3) * B + e.w + 3);
    chk("rsqrt_in", var_seen, e.ev);
    chk("rsqrt_stable", var_jump, 0);
    chk("req_cycles", req_cnt, e.w);
    chk("y_out", y_out, e.ey);
    chk("out_valid", out_valid, 1);
    chk("busy_clr", busy, 0);
    @(posedge clk); #1 chk("done_pulse", done, 0);
    repeat (3) @(posedge clk);
    #1 chk("stay_idle", busy, 0);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b1; start = 1'b0; mode = 1'b0;
    x_in = '0; gamma = '0; beta = '0;
    #2 rst_n = 1'b0;

    //          mode xa     xb     gamma  beta   rs        w   rst ev     ya     yb
    tbl[0] = mk(0, 8'h05, 8'h05, 16'd5120, 8'hF9, 16'hFFFF, 1,  0, 16'd0,     8'hF9, 8'hF9);
    tbl[1] = mk(0, 8'h04, 8'hFC, 16'd5120, 8'h00, 16'd1024, 1,  0, 16'd16,    8'h14, 8'hEC);
    tbl[2] = mk(1, 8'h03, 8'h03, 16'd5120, 8'h00, 16'd1365, 1,  0, 16'd9,     8'h14, 8'h14);
    tbl[3] = mk(0, 8'h64, 8'h9C, 16'd5120, 8'h78, 16'd41,   1,  0, 16'd10000, 8'h7F, 8'h64);
    tbl[4] = mk(0, 8'h04, 8'hFC, 16'd5120, 8'h00, 16'd1024, 10, 3, 16'd16,    8'h14, 8'hEC);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_y_out", y_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req", rsqrt_req, 0);
    chk("rst_rsqrt_in", rsqrt_in, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run(tbl[i]);

    for (int k = 0; k < 4; k++) begin
      v.mode = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        v.x[i] = 8'($urandom);
        v.g[i] = 16'($urandom);
        v.b[i] = 8'($urandom);
      end
      v.rs = 16'($urandom);
      v.w = $urandom_range(1, 4);
      v.restart = 0;
      run(model(v));
    end

    // Reset in the middle of OUT, after the first beat has been written.
    @(negedge clk);
    x_in = tbl[1].x; gamma = tbl[1].g; beta = tbl[1].b; mode = 1'b0;
    rs_val = tbl[1].rs; ack_w = 1; req_cnt = 0; var_jump = 0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    chk("partial_y", y_out[3:0], tbl[1].ey[3:0]);
    rst_n = 1'b0;
    #1;
    chk("abort_y_out", y_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_req", rsqrt_req, 0);
    @(negedge clk) rst_n = 1'b1;
    run(tbl[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/layer_norm_lanes.md
Name: layer_norm_lanes

Overview:
- Parametrised successor to the single-lane layer normaliser in the NPU norm path. It normalises one N-element signed vector, processing P elements per cycle.
- Two modes: LayerNorm (subtract the mean, divide by the standard deviation) and RMSNorm (no mean subtraction).
- Scale gamma and shift beta are applied per element.
- Reciprocal square root comes from the shared rsqrt unit over a req/ack handshake. Outputs are a registered int vector plus a valid flag.

Parameters:
- N, 176, vector length; must be a multiple of P.
- P, 4, lanes processed per cycle.
- DW, 8, x / y / beta width (signed).
- GW, 16, gamma width (signed fixed point).
- GSH, 8, right shift applied after the gamma multiply.
- RSH, 12, fractional bits of rsqrt_out.
- AVG_MUL, 93, reciprocal multiplier, equal to round(2^AVG_SHIFT / N).
- AVG_SHIFT, 14, shift paired with AVG_MUL.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle start pulse; honoured only in IDLE
- mode  in  1  0 = LayerNorm, 1 = RMSNorm; sampled at the accepted start
- x_in  in  N x DW  signed input vector; held stable from start until done
- gamma  in  N x GW  signed per-element scale; held stable
- beta  in  N x DW  signed per-element shift; held stable
- rsqrt_req  out  1  request to the rsqrt unit
- rsqrt_in  out  16  unsigned variance operand
- rsqrt_ack  in  1  rsqrt result valid
- rsqrt_out  in  16  unsigned 1/sqrt(var), RSH fractional bits
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse when y_out is complete
- y_out  out  N x DW  signed normalised result, registered
- out_valid  out  1  set with done; cleared on the next accepted start

Behaviour:
- Reset (clk/rst_n as already decided): reset rst_n, asynchronous, active-low; clock clk. Every output resets to 0 (including all y_out), state goes to IDLE, and all accumulators clear. Asserting reset mid-operation aborts the pass with no done.
- States: IDLE -> MEAN -> VAR -> RSQRT -> OUT -> DRAIN -> IDLE. Let B = N/P beats.
- IDLE:
  - start=1 latches mode, clears the beat index and accumulator, and sets busy.
  - Next state is MEAN, or VAR directly when mode=1, in which case mean is forced to 0.
  - start while busy is ignored and causes no state change.
- MEAN (B cycles):
  - Each beat adds the P lane values x[k*P+j] to a signed accumulator wide enough for N*2^(DW-1).
  - After the last beat: mean = sat_DW(floor((sum*AVG_MUL) >>> AVG_SHIFT)).
  - Accumulator clears; go to VAR.
- VAR (B cycles):
  - xd = x - mean, DW+1 bits, no saturation.
  - Accumulate the P values xd^2 per beat, unsigned.
  - After the last beat: var = sat_u16(floor((sumsq*AVG_MUL) >> AVG_SHIFT)). Go to RSQRT.
- RSQRT:
  - rsqrt_req=1, with rsqrt_in=var held constant, until the first cycle with rsqrt_ack=1.
  - rsqrt_out is captured into r on that cycle; req drops the next cycle and state goes to OUT. Any ack-wait length is allowed.
  - An ack seen outside RSQRT is ignored.
- OUT (B issue cycles): two-stage pipeline per lane.
  - Stage 1: n = (xd*r + 2^(RSH-1)) >>> RSH, signed, kept at 24 bits.
  - Stage 2: g = (n*gamma) >>> GSH (arithmetic, floor); y = sat_DW(g + beta).
  - y_out for beat k is written 2 cycles after issue of beat k.
  - Lanes never write outside their own beat's slots.
- DRAIN:
  - Two cycles to flush the pipeline.
  - On the cycle after the last y_out write: done=1 for one cycle, out_valid=1, busy=0, state IDLE.
- Latency from the start edge to done:
  - LayerNorm: 2B + W + B + 3 cycles, where W ≥ 1 is the number of RSQRT cycles.
  - RMSNorm: the same minus B.
- sat_DW clamps to [-2^(DW-1), 2^(DW-1)-1]. All shifts of signed values are arithmetic.
- y_out holds its values until overwritten by the next operation. out_valid drops on the accepted start; y_out entries update progressively during OUT.
- Var = 0 passes through unchanged; rsqrt saturation is the rsqrt unit's responsibility.

Test Plan:
Parameters for all tests: N=8, P=4, AVG_MUL=2048, AVG_SHIFT=14. The bench models rsqrt with the stated ack delays.
- Flat vector, LN: x all 5, gamma 5120, beta -7, rsqrt_out=0xFFFF (ack after 1 cycle) -> mean 5, rsqrt_in=0, every y=-7, done 10 cycles after start, out_valid=1.
- Alternating x = +4,-4,..., LN, beta 0, gamma 5120, rsqrt_out=1024 -> rsqrt_in=16, y alternates +20,-20.
- RMSNorm: x all 3, mode=1, rsqrt_out=1365, gamma 5120, beta 0 -> rsqrt_in=9, y all 20, MEAN skipped (done 8 cycles after start with a 1-cycle ack).
- Saturation: x = +100,-100,..., rsqrt_out=41, gamma 5120, beta 120 -> rsqrt_in=10000, y alternates 127 (clamped from 140) and 100.
- Handshake: rsqrt_ack delayed 10 cycles with start pulsed again mid-VAR -> req held 10 cycles with rsqrt_in constant, second start ignored, single done pulse.
- Reset mid-OUT: assert rst_n=0 -> y_out all 0, busy, done and out_valid 0, IDLE; a following start completes normally.
